// File: rtl/riscv_pkg.sv
// Shared fetch-side types and width defaults for the instruction prefetch path.
package riscv_pkg;

  localparam int ADDR_SIZE_DEF = 10;
  localparam int DATA_SIZE_DEF = 32;

  typedef struct packed {
    logic [ADDR_SIZE_DEF+1:0] pc;
    logic [DATA_SIZE_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is carried entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: credit-limited sequential fetch from a 1-cycle ROM into
// a small queue, with redirect/CLEAR flush and an asynchronous reset.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLEAR,
  output logic [ADDR_SIZE-1:0] iaddr,
  input  logic [DATA_SIZE-1:0] idata,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE+1:0] redirect_pc,
  output logic                 inst_valid,
  output logic [DATA_SIZE-1:0] inst,
  output logic [ADDR_SIZE+1:0] inst_pc,
  input  logic                 inst_ready
);

  localparam int PC_W    = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = $bits(fetch_entry_t);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  infl_pc_q, infl_pc_d;
  logic             infl_valid_q, infl_valid_d;
  logic [PC_W-1:0]  target, fetch_addr;
  logic             flush, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head_entry;

  // The flush cycle itself fetches the target, so it lands two cycles later.
  always_comb begin
    flush        = CLEAR || redirect_valid;
    target       = CLEAR ? '0 : {redirect_pc[PC_W-1:2], 2'b00};
    fetch_addr   = fetch_pc_q;
    fetch_pc_d   = fetch_pc_q;
    infl_valid_d = 1'b0;
    infl_pc_d    = infl_pc_q;
    if (flush) begin
      fetch_addr   = target;
      fetch_pc_d   = target + PC_W'(4);
      infl_valid_d = 1'b1;
      infl_pc_d    = target;
    end else if ((int'(fifo_count) + int'(infl_valid_q)) < DEPTH) begin
      fetch_pc_d   = fetch_pc_q + PC_W'(4);
      infl_valid_d = 1'b1;
      infl_pc_d    = fetch_pc_q;
    end
  end

  assign iaddr = RESET ? '0 : fetch_addr[PC_W-1:2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_q   <= '0;
      infl_pc_q    <= '0;
      infl_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      infl_pc_q    <= infl_pc_d;
      infl_valid_q <= infl_valid_d;
    end
  end

  always_comb begin
    push_entry.pc    = infl_pc_q;
    push_entry.instr = idata;
    push             = infl_valid_q && !flush;
    pop              = inst_valid && inst_ready && !flush;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (CLK),
    .rst   (RESET),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs read zero whenever the head slot holds nothing valid.
  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head_entry.instr : '0;
  assign inst_pc    = inst_valid ? head_entry.pc : '0;

  push_when_full_a: assert property (@(posedge CLK) disable iff (RESET) !(push && fifo_full));

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios followed by random
// ready/redirect/CLEAR traffic, checked against an instruction-stream model.
module tb_if_prefetch;

  localparam int ADDR_SIZE = 10;
  localparam int DATA_SIZE = 32;
  localparam int DEPTH     = 4;
  localparam int PC_W      = ADDR_SIZE + 2;

  logic                 CLK = 1'b0;
  logic                 RESET, CLEAR, redirect_valid, inst_ready;
  logic [ADDR_SIZE-1:0] iaddr;
  logic [DATA_SIZE-1:0] idata, inst;
  logic [PC_W-1:0]      redirect_pc, inst_pc;
  logic                 inst_valid;

  int total = 0;
  int fails = 0;

  // Model state: the next PC the decoder must see, and cycles since the last flush.
  logic [PC_W-1:0]      exp_pc;
  int                   since_flush;
  logic                 prev_stall;
  logic [PC_W-1:0]      prev_pc;
  logic [DATA_SIZE-1:0] prev_inst;

  if_prefetch #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CLEAR          (CLEAR),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DATA_SIZE-1:0] rom_word(input logic [ADDR_SIZE-1:0] k);
    return 32'h0000_0013 + 32'(k);
  endfunction

  // Synchronous ROM: data for the sampled address appears the following cycle.
  always @(posedge CLK) idata <= rom_word(iaddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic            flush;
    logic [PC_W-1:0] tgt;
    since_flush++;
    if (since_flush == 1) check("bubble_after_flush", 32'(inst_valid), 32'd0);
    if (since_flush == 2) check("valid_two_after_flush", 32'(inst_valid), 32'd1);
    if (prev_stall) begin
      check("stall_pc_hold", 32'(inst_pc), 32'(prev_pc));
      check("stall_inst_hold", inst, prev_inst);
    end
    if (inst_valid) begin
      check("head_pc", 32'(inst_pc), 32'(exp_pc));
      check("head_inst", inst, rom_word(exp_pc[PC_W-1:2]));
    end
    flush = CLEAR || redirect_valid;
    if (flush) begin
      tgt = CLEAR ? '0 : PC_W'((int'(redirect_pc) / 4) * 4);
      check("flush_iaddr", 32'(iaddr), 32'(tgt) / 4);
      exp_pc      = tgt;
      since_flush = 0;
    end else if (inst_valid && inst_ready) begin
      exp_pc = exp_pc + PC_W'(4);
    end
    prev_stall = inst_valid && !inst_ready && !flush;
    prev_pc    = inst_pc;
    prev_inst  = inst;
  endtask

  task automatic cycle(input logic rdy, input logic redir, input logic [PC_W-1:0] rpc,
                       input logic clr);
    @(posedge CLK);
    #1;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    CLEAR          = clr;
    #1;
    model_check();
  endtask

  // Reset release behaves like a flush to PC 0 in the first cycle after deassertion.
  task automatic release_reset();
    @(posedge CLK);
    #1;
    RESET          = 1'b0;
    CLEAR          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    #1;
    check("release_iaddr", 32'(iaddr), 32'd0);
    check("release_valid", 32'(inst_valid), 32'd0);
    exp_pc      = '0;
    since_flush = 0;
    prev_stall  = 1'b0;
  endtask

  initial begin
    int                   nvalid;
    logic [ADDR_SIZE-1:0] frozen;
    logic                 rr, rd, cl;

    RESET          = 1'b1;
    CLEAR          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h040;
    inst_ready     = 1'b0;
    exp_pc         = '0;
    since_flush    = 100;
    prev_stall     = 1'b0;
    prev_pc        = '0;
    prev_inst      = '0;
    frozen         = '0;

    repeat (3) @(posedge CLK);
    #2;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_iaddr", 32'(iaddr), 32'd0);

    // Sequential stream at full rate.
    release_reset();
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      if (inst_valid) nvalid++;
    end
    check("throughput", 32'(nvalid), 32'd11);

    // Ten-cycle stall: queue fills to DEPTH, fetch address freezes.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      if (i == 5) frozen = iaddr;
    end
    check("iaddr_frozen", 32'(iaddr), 32'(frozen));
    check("queued_depth", 32'(iaddr), 32'(exp_pc[PC_W-1:2]) + 32'(DEPTH));
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);

    // Redirect while full, with ready high in the flush cycle.
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 12'h040, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);

    // CLEAR beats a simultaneous redirect.
    cycle(1'b1, 1'b1, 12'h080, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b0);

    // Misaligned target is truncated.
    cycle(1'b1, 1'b1, 12'h1A3, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b0);

    // Wrap past the top of the address space.
    cycle(1'b1, 1'b1, 12'hFF0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, '0, 1'b0);

    // Asynchronous reset with three entries queued.
    cycle(1'b0, 1'b1, 12'h100, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);
    @(posedge CLK);
    #2;
    check("pre_reset_valid", 32'(inst_valid), 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_inst", inst, 32'd0);
    check("async_rst_pc", 32'(inst_pc), 32'd0);
    check("async_rst_iaddr", 32'(iaddr), 32'd0);
    release_reset();
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 39) == 0);
      cycle(rr, rd, PC_W'($urandom_range(0, 4095)), cl);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 10, ROM word-address width.
REQ-002 SHALL have parameter DATA_SIZE, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port CLEAR  input  1  synchronous flush; equivalent to redirect to PC 0.
REQ-007 SHALL have port iaddr  output  ADDR_SIZE  ROM word address, equal to fetch_pc[ADDR_SIZE+1:2].
REQ-008 SHALL have port idata  input  DATA_SIZE  ROM read data, valid one cycle after iaddr is sampled.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken, from execute.
REQ-010 SHALL have port redirect_pc  input  ADDR_SIZE+2  byte-address target.
REQ-011 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port inst  output  DATA_SIZE  head instruction.
REQ-013 SHALL have port inst_pc  output  ADDR_SIZE+2  byte PC of head instruction.
REQ-014 SHALL have port inst_ready  input  1  decode accepts head this cycle (low = stall).

Function
REQ-015 SHALL keep fetch_pc (ADDR_SIZE+2 bits), incremented by 4 per issued fetch, wrapping modulo 2^(ADDR_SIZE+2).
REQ-016 SHALL issue a fetch in a cycle only when occupancy + in-flight count < DEPTH, no redirect/CLEAR is active in that cycle and reset is low.
REQ-017 SHALL track one in-flight fetch (valid bit, PC); on the next cycle write {idata, PC} into the queue if still valid.
REQ-018 SHALL pop the head when inst_valid && inst_ready; pop and push in the same cycle SHALL leave occupancy unchanged.
REQ-019 SHALL never push when the queue is full; the credit rule of REQ-016 guarantees this, and an assertion SHALL check it.
REQ-020 SHALL, on redirect_valid or CLEAR: empty the queue, invalidate the in-flight fetch, drive iaddr from the target (redirect_pc, or 0 for CLEAR) combinationally in that cycle, and set fetch_pc = target + 4.
REQ-021 SHALL force redirect_pc[1:0] to 0 (misaligned targets truncated).
REQ-022 SHALL give the redirect target first as inst_valid with inst_pc = target two cycles after the redirect cycle (ROM cycle + queue write).
REQ-023 SHALL ignore inst_ready in a redirect/CLEAR cycle: flush wins over pop.
REQ-024 SHALL give CLEAR priority over redirect_valid when both are asserted.
REQ-025 SHALL hold inst and inst_pc stable while inst_valid && !inst_ready.
REQ-026 SHALL reach steady-state throughput of one instruction per cycle with inst_ready held high.

Reset
REQ-027 SHALL, while RESET is high: fetch_pc=0, iaddr=0, queue empty, in-flight invalid, inst_valid=0, inst=0, inst_pc=0.
REQ-028 SHALL, on reset assertion mid-operation, discard all queued and in-flight instructions immediately (asynchronously).
REQ-029 SHALL issue the first fetch (PC 0) in the first cycle after RESET deasserts; inst_valid with inst_pc=0 two cycles later.

Structure
REQ-030 SHALL take ADDR_SIZE/DATA_SIZE defaults and the fetch-entry struct {pc, instr} from shared package riscv_pkg.
REQ-031 SHALL implement the queue as sub-module sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty).
REQ-032 SHALL contain no combinational path from idata to inst.

Verification
REQ-033 SHALL cover reset release, ROM word k = 0x00000013+k, inst_ready=1 -> inst_pc 0,4,8,... one per cycle from cycle 2.
REQ-034 SHALL cover inst_ready=0 for 10 cycles -> exactly DEPTH entries queued, iaddr frozen, no loss/duplication on release.
REQ-035 SHALL cover redirect_pc=0x40 while queue full -> queue flushed, next inst_pc=0x40 two cycles later, then 0x44.
REQ-036 SHALL cover redirect and CLEAR in the same cycle with redirect_pc=0x80 -> next inst_pc=0.
REQ-037 SHALL cover fetch_pc reaching 0xFFC (ADDR_SIZE=10) -> following inst_pc=0x000.
REQ-038 SHALL cover RESET pulsed with 3 entries queued -> inst_valid falls asynchronously; restart from PC 0.
